// File: rtl/mux4_sel_scanner_if.sv
// Signal bundle between the select scanner, the downstream 4:1 mux and the snapshot consumer.
interface mux4_sel_scanner_if #(
    parameter int DWELL_W = 8
);
    logic               Enable;
    logic [3:0]         Mask;
    logic [DWELL_W-1:0] Dwell;
    logic               MuxOut;
    logic               Ack;
    logic               Sel1;
    logic               Sel0;
    logic [3:0]         Sample;
    logic               Valid;
    logic               Busy;
    logic               Overrun;

    // master: the scanner itself; slave: the environment (mux, consumer, control)
    modport master (
        input  Enable, Mask, Dwell, MuxOut, Ack,
        output Sel1, Sel0, Sample, Valid, Busy, Overrun
    );
    modport slave (
        output Enable, Mask, Dwell, MuxOut, Ack,
        input  Sel1, Sel0, Sample, Valid, Busy, Overrun
    );
endinterface

// File: rtl/mux4_sel_scanner.sv
// Round-robin select sequencer for a 4:1 mux: steps Sel1/Sel0 over the enabled channels,
// samples the returned mux output once per channel and publishes a snapshot per sweep.
module mux4_sel_scanner #(
    parameter int DWELL_W = 8,
    parameter int SETTLE  = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    mux4_sel_scanner_if.master bus,
    output logic [1:0]         dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DWELL  = 2'd2
    } state_t;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam state_t SLOT_FIRST = (SETTLE == 0) ? S_DWELL : S_SETTLE;

    state_t             state_q, state_d;
    logic [1:0]         chan_q, chan_d;
    logic [3:0]         mask_l_q, mask_l_d;
    logic [DWELL_W-1:0] dwell_l_q, dwell_l_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic [SW-1:0]      scnt_q, scnt_d;
    logic [3:0]         shadow_q, shadow_d;
    logic [3:0]         sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

    logic               start_ok;
    logic [DWELL_W-1:0] dwell_eff;
    logic [3:0]         captured;
    logic [3:0]         above;
    logic               do_launch;
    logic               do_idle;
    logic               publish;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) r = 2'(k);
        end
        return r;
    endfunction

    assign start_ok  = bus.Enable && (bus.Mask != 4'b0000);
    assign dwell_eff = (bus.Dwell == '0) ? DWELL_W'(1) : bus.Dwell;

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        mask_l_d  = mask_l_q;
        dwell_l_d = dwell_l_q;
        dcnt_d    = dcnt_q;
        scnt_d    = scnt_q;
        shadow_d  = shadow_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        do_launch = 1'b0;
        do_idle   = 1'b0;
        publish   = 1'b0;
        captured  = shadow_q;
        captured[chan_q] = bus.MuxOut;
        // enabled channels strictly above the current one
        above     = mask_l_q & ~((4'b0010 << chan_q) - 4'b0001);

        case (state_q)
            S_IDLE: do_launch = start_ok;
            S_SETTLE: begin
                if (!bus.Enable) begin
                    do_idle = 1'b1;
                end else if (scnt_q == SETTLE_LAST) begin
                    state_d = S_DWELL;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            S_DWELL: begin
                if (dcnt_q == dwell_l_q - 1'b1) begin
                    if (above != 4'b0000) begin
                        if (!bus.Enable) begin
                            do_idle = 1'b1;
                        end else begin
                            shadow_d = captured;
                            chan_d   = lowest(above);
                            state_d  = SLOT_FIRST;
                            dcnt_d   = '0;
                            scnt_d   = '0;
                        end
                    end else begin
                        publish   = 1'b1;
                        do_launch = start_ok;
                        do_idle   = !start_ok;
                    end
                end else if (!bus.Enable) begin
                    do_idle = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: do_idle = 1'b1;
        endcase

        if (do_launch) begin
            mask_l_d  = bus.Mask;
            dwell_l_d = dwell_eff;
            chan_d    = lowest(bus.Mask);
            shadow_d  = '0;
            state_d   = SLOT_FIRST;
            dcnt_d    = '0;
            scnt_d    = '0;
        end
        if (do_idle) begin
            state_d  = S_IDLE;
            chan_d   = 2'd0;
            shadow_d = '0;
            dcnt_d   = '0;
            scnt_d   = '0;
        end

        // Valid/Ack: Valid rises on publish and holds until an edge with Ack=1 and no
        // publish; a publish always wins over Ack; publishing over an unacked Valid sets Overrun.
        if (publish) begin
            sample_d = captured & mask_l_q;
            valid_d  = 1'b1;
            if (valid_q && !bus.Ack) overrun_d = 1'b1;
        end else if (bus.Ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            chan_q    <= 2'd0;
            mask_l_q  <= '0;
            dwell_l_q <= '0;
            dcnt_q    <= '0;
            scnt_q    <= '0;
            shadow_q  <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            mask_l_q  <= mask_l_d;
            dwell_l_q <= dwell_l_d;
            dcnt_q    <= dcnt_d;
            scnt_q    <= scnt_d;
            shadow_q  <= shadow_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.Sel1    = chan_q[1];
    assign bus.Sel0    = chan_q[0];
    assign bus.Sample  = sample_q;
    assign bus.Valid   = valid_q;
    assign bus.Busy    = (state_q != S_IDLE);
    assign bus.Overrun = overrun_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mux4_sel_scanner.sv
// Bench for mux4_sel_scanner: slot-arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mux4_sel_scanner;
    localparam int DWELL_W = 8;
    localparam int SETTLE  = 1;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] in_vec;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad = 0;

    mux4_sel_scanner_if #(.DWELL_W(DWELL_W)) bus ();

    mux4_sel_scanner #(.DWELL_W(DWELL_W), .SETTLE(SETTLE)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // downstream 4:1 mux
    assign bus.MuxOut = in_vec[{bus.Sel1, bus.Sel0}];

    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    int         cyc = 0;
    bit         m_active = 1'b0;
    int         m_e0 = 0;
    int         m_t = 1;
    int         m_chans[$];
    logic [3:0] m_mask = 4'b0;
    logic [3:0] m_shadow = 4'b0;
    logic [3:0] m_sample = 4'b0;
    logic       m_valid = 1'b0;
    logic       m_overrun = 1'b0;

    task automatic model_reset();
        m_active = 1'b0; m_shadow = 4'b0; m_sample = 4'b0;
        m_valid = 1'b0; m_overrun = 1'b0; m_chans.delete();
    endtask

    task automatic model_start();
        m_mask = bus.Mask;
        m_t = SETTLE + ((bus.Dwell == 0) ? 1 : int'(bus.Dwell));
        m_chans.delete();
        for (int k = 0; k < 4; k++) if (bus.Mask[k]) m_chans.push_back(k);
        m_shadow = 4'b0;
        m_e0 = cyc;
        m_active = 1'b1;
    endtask

    task automatic model_edge();
        int k;
        bit pub;
        logic [3:0] pub_val;
        logic en, ack;
        en = bus.Enable; ack = bus.Ack;
        pub = 1'b0; pub_val = 4'b0;
        cyc++;
        if (m_active) begin
            k = cyc - m_e0;
            if (k % m_t == 0) begin
                m_shadow[m_chans[k / m_t - 1]] = in_vec[m_chans[k / m_t - 1]];
                if (k / m_t == m_chans.size()) begin
                    pub = 1'b1;
                    pub_val = m_shadow & m_mask;
                    m_active = 1'b0;
                    if (en && bus.Mask != 4'b0) model_start();
                end else if (!en) begin
                    m_active = 1'b0;
                end
            end else if (!en) begin
                m_active = 1'b0;
            end
        end else if (en && bus.Mask != 4'b0) begin
            model_start();
        end
        if (pub) begin
            if (m_valid && !ack) m_overrun = 1'b1;
            m_valid = 1'b1;
            m_sample = pub_val;
        end else if (ack) begin
            m_valid = 1'b0;
        end
    endtask

    function automatic logic [1:0] exp_sel();
        if (!m_active) return 2'd0;
        return 2'(m_chans[(cyc - m_e0) / m_t]);
    endfunction

    initial begin
        forever begin
            @(posedge Clk or posedge Reset);
            if (Reset) model_reset();
            else model_edge();
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            check("mdl_sel", {30'b0, bus.Sel1, bus.Sel0}, {30'b0, exp_sel()});
            check("mdl_busy", {31'b0, bus.Busy}, {31'b0, m_active});
            check("mdl_valid", {31'b0, bus.Valid}, {31'b0, m_valid});
            check("mdl_sample", {28'b0, bus.Sample}, {28'b0, m_sample});
            check("mdl_overrun", {31'b0, bus.Overrun}, {31'b0, m_overrun});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic edges(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic drive(input logic en, input logic [3:0] mask, input logic [DWELL_W-1:0] dw);
        bus.Enable = en; bus.Mask = mask; bus.Dwell = dw;
    endtask

    task automatic pulse_ack();
        bus.Ack = 1'b1; edges(1); bus.Ack = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int exp_n);
        int n = 0;
        while (bus.Valid !== 1'b1 && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        check(nm, n, exp_n);
    endtask

    logic [1:0] seq1 [12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [1:0] seq2 [6]  = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2};

    initial begin
        Reset = 1'b1;
        in_vec = 4'b0;
        bus.Ack = 1'b0;
        drive(1'b0, 4'b0, '0);
        edges(2);
        check("rst_sel", {30'b0, bus.Sel1, bus.Sel0}, 32'd0);
        check("rst_valid", {31'b0, bus.Valid}, 32'd0);
        check("rst_busy", {31'b0, bus.Busy}, 32'd0);
        Reset = 1'b0;
        edges(1);

        // full sweep, Mask=1111, T=3
        in_vec = 4'b1010;
        drive(1'b1, 4'b1111, 8'd2);
        edges(1);
        for (int i = 0; i < 12; i++) begin
            check("t1_sel", {30'b0, bus.Sel1, bus.Sel0}, {30'b0, seq1[i]});
            check("t1_busy", {31'b0, bus.Busy}, 32'd1);
            check("t1_valid_low", {31'b0, bus.Valid}, 32'd0);
            edges(1);
        end
        check("t1_valid", {31'b0, bus.Valid}, 32'd1);
        check("t1_sample", {28'b0, bus.Sample}, 32'b1010);
        bus.Enable = 1'b0;
        edges(1);
        pulse_ack();
        check("t1_ack_clears", {31'b0, bus.Valid}, 32'd0);

        // sparse mask
        in_vec = 4'b1111;
        drive(1'b1, 4'b0101, 8'd2);
        edges(1);
        for (int i = 0; i < 6; i++) begin
            check("t2_sel", {30'b0, bus.Sel1, bus.Sel0}, {30'b0, seq2[i]});
            edges(1);
        end
        check("t2_valid", {31'b0, bus.Valid}, 32'd1);
        check("t2_sample", {28'b0, bus.Sample}, 32'b0101);
        bus.Enable = 1'b0;
        edges(1);
        pulse_ack();

        // handshake and overrun, T=2
        drive(1'b1, 4'b0001, 8'd1);
        edges(1);
        edges(2);
        check("t3_pub1_valid", {31'b0, bus.Valid}, 32'd1);
        check("t3_pub1_ovr", {31'b0, bus.Overrun}, 32'd0);
        edges(2);
        check("t3_pub2_ovr", {31'b0, bus.Overrun}, 32'd1);
        edges(1);
        bus.Ack = 1'b1;
        edges(1);
        check("t3_pub_ack_valid", {31'b0, bus.Valid}, 32'd1);
        check("t3_pub_ack_ovr", {31'b0, bus.Overrun}, 32'd1);
        bus.Enable = 1'b0;
        edges(1);
        bus.Ack = 1'b0;
        check("t3_ack_clears", {31'b0, bus.Valid}, 32'd0);

        // async reset during channel 1
        in_vec = 4'b1010;
        drive(1'b1, 4'b1111, 8'd2);
        edges(1);
        edges(4);
        check("t4_pre_sel", {30'b0, bus.Sel1, bus.Sel0}, 32'd1);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("t4_async_sel", {30'b0, bus.Sel1, bus.Sel0}, 32'd0);
        check("t4_async_busy", {31'b0, bus.Busy}, 32'd0);
        check("t4_async_ovr", {31'b0, bus.Overrun}, 32'd0);
        check("t4_async_sample", {28'b0, bus.Sample}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        edges(1);
        check("t4_restart_sel", {30'b0, bus.Sel1, bus.Sel0}, 32'd0);
        wait_valid("t4_valid_latency", 12);
        check("t4_sample", {28'b0, bus.Sample}, 32'b1010);

        // enable drop during channel 2 dwell of the back-to-back sweep
        in_vec = 4'b0110;
        edges(7);
        check("t5_ch2_sel", {30'b0, bus.Sel1, bus.Sel0}, 32'd2);
        bus.Enable = 1'b0;
        edges(1);
        check("t5_abort_sel", {30'b0, bus.Sel1, bus.Sel0}, 32'd0);
        check("t5_abort_busy", {31'b0, bus.Busy}, 32'd0);
        check("t5_keep_valid", {31'b0, bus.Valid}, 32'd1);
        check("t5_keep_sample", {28'b0, bus.Sample}, 32'b1010);
        pulse_ack();
        drive(1'b1, 4'b1111, 8'd2);
        edges(1);
        wait_valid("t5_valid_latency", 12);
        check("t5_sample", {28'b0, bus.Sample}, 32'b0110);
        bus.Enable = 1'b0;
        edges(1);
        pulse_ack();

        // Dwell=0 acts as 1
        in_vec = 4'b0010;
        drive(1'b1, 4'b0010, 8'd0);
        edges(1);
        wait_valid("t6_dwell0_latency", 2);
        check("t6_dwell0_sample", {28'b0, bus.Sample}, 32'b0010);
        bus.Enable = 1'b0;
        edges(1);
        pulse_ack();

        // Mask=0000 stays idle
        drive(1'b1, 4'b0000, 8'd2);
        edges(5);
        check("t6_mask0_busy", {31'b0, bus.Busy}, 32'd0);
        check("t6_mask0_valid", {31'b0, bus.Valid}, 32'd0);
        bus.Enable = 1'b0;

        // mask change mid-sweep applies to the next sweep only
        in_vec = 4'b1111;
        drive(1'b1, 4'b0011, 8'd1);
        edges(1);
        bus.Mask = 4'b1100;
        wait_valid("t6_mchg_latency1", 4);
        check("t6_mchg_sample1", {28'b0, bus.Sample}, 32'b0011);
        check("t6_mchg_sel_next", {30'b0, bus.Sel1, bus.Sel0}, 32'd2);
        pulse_ack();
        wait_valid("t6_mchg_latency2", 3);
        check("t6_mchg_sample2", {28'b0, bus.Sample}, 32'b1100);
        check("t6_mchg_ovr", {31'b0, bus.Overrun}, 32'd0);
        bus.Enable = 1'b0;
        edges(1);
        pulse_ack();

        // Dwell all-ones, no wrap: T = 1 + 255
        in_vec = 4'b0001;
        drive(1'b1, 4'b0001, 8'hFF);
        edges(1);
        wait_valid("t6_dwellmax_latency", 256);
        check("t6_dwellmax_sample", {28'b0, bus.Sample}, 32'b0001);
        bus.Enable = 1'b0;
        edges(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux4_sel_scanner.md
Name: mux4_sel_scanner

Overview:
Round-robin select sequencer that sits directly upstream of the 4:1 structural mux. It drives the mux select lines Sel1/Sel0 and samples the returned mux output once per channel. After each full sweep it publishes a 4-bit snapshot of all enabled channels through a Valid/Ack handshake. The dwell time per channel, the settle delay after each select change, and the channel mask are all configurable.

Parameters:
DWELL_W, 8, width of the Dwell input and of the dwell counter
SETTLE, 1, cycles after a select change before dwell counting starts (0 allowed)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Enable  input  1  run scanner; low forces a return to IDLE
Mask  input  4  channel enable; Mask[k]=1 means channel k is scanned
Dwell  input  DWELL_W  dwell cycles per channel; 0 is treated as 1
MuxOut  input  1  mux Out, fed back from the downstream 4:1 mux
Ack  input  1  consumer acknowledge of Sample
Sel1  output  1  mux select MSB
Sel0  output  1  mux select LSB
Sample  output  4  published snapshot; Sample[k] = channel k value, disabled bits forced 0
Valid  output  1  Sample holds unacknowledged data
Busy  output  1  a sweep is in progress
Overrun  output  1  sticky; a sweep completed while Valid was still pending

Behaviour:
- Reset (async, active-high): all state and outputs go to 0 immediately. State=IDLE, {Sel1,Sel0}=00, Sample=0000, Valid=0, Busy=0, Overrun=0, counters and shadow register=0.
- States: IDLE, SETTLE, DWELL.
- Sweep start (IDLE):
  - On an edge where Enable=1 and Mask!=0, latch Mask to MaskL and Dwell to DwellL (0 becomes 1).
  - Select the lowest enabled channel, set Busy=1, clear the shadow register.
  - Go to SETTLE, or straight to DWELL when SETTLE=0.
  - Enable=1 with Mask=0000: stay in IDLE, no activity.
- SETTLE: hold the select for SETTLE cycles, then go to DWELL.
- DWELL: hold the select for DwellL cycles. On the edge ending the last dwell cycle:
  - shadow[chan] <= MuxOut;
  - advance to the next higher channel k with MaskL[k]=1 and go to SETTLE/DWELL.
- Sweep end: no higher enabled channel remains.
  - Sample <= shadow with the captured bit included and disabled bits forced 0; Valid <= 1.
  - If Enable=1: relatch Mask/Dwell and start the next sweep on the same edge, with no idle cycle.
  - If Enable=0: go to IDLE, Busy=0, select=00.
- Timing: slot length per channel is T = SETTLE + DwellL. With N enabled channels and E0 the starting edge, channel i (0-based in scan order) is sampled at edge E0 + (i+1)*T, and Valid rises at edge E0 + N*T.
- Select changes only at slot boundaries, so Sel1/Sel0 are glitch-free registered outputs.
- Handshake:
  - Valid stays high until an edge with Ack=1 clears it.
  - Ack while Valid=0 is ignored.
  - Publish and Ack on the same edge: the new data wins, Valid stays 1, no overrun.
  - Publish while Valid=1 and Ack=0: Sample is overwritten and Overrun is set. Overrun clears only on Reset.
- Enable dropped mid-sweep: abort on the next edge. Go to IDLE, select=00, Busy=0, discard the shadow register. Sample and Valid are unchanged.
- Mask or Dwell changed mid-sweep: no effect until the next sweep start.
- Reset mid-sweep: immediate return to the reset values above; a sweep restarts only after Reset deasserts and Enable is sampled high.
- Dwell counter is DWELL_W bits; Dwell=all-ones gives 2^DWELL_W-1 cycles with no wrap-around.

Test Plan:
- Full sweep: SETTLE=1, Dwell=2, Mask=1111, mux inputs In3..In0=1,0,1,0, Ack held 0 → select sequence 00,01,10,11 with 3 cycles each; Valid rises 12 edges after start; Sample=1010; Busy=1 throughout.
- Sparse mask: Mask=0101, inputs all 1 → only selects 00 and 10 appear; Valid after 6 edges; Sample=0101.
- Handshake and overrun: continuous Enable, Ack held 0 → second publish sets Overrun=1. Then pulse Ack on the same edge as the third publish → Valid stays 1, Overrun remains 1. Ack on a non-publish edge → Valid=0.
- Enable drop: deassert Enable during channel 2 dwell → next edge: select=00, Busy=0; Sample/Valid keep their prior values; the restarted sweep produces correct data.
- Async reset mid-sweep: assert Reset between clock edges during channel 1 → all outputs 0 immediately, without waiting for a clock edge; after release with Enable=1, the sweep restarts from channel 0.
- Boundaries: Dwell=0 behaves as Dwell=1 (T=SETTLE+1); Enable=1 with Mask=0000 → stays in IDLE, Busy=0; Mask changed mid-sweep → current sweep uses the old mask, the next sweep uses the new one.
